alu_inst_sequencer: RTL and testbench
=====================================

// Module: alu_inst_sequencer
// PURPOSE
//  Sequences a stored program of 10-bit instruction words through the 4-bit combinational ALU.
//  - Words are loaded over a write port, then issued one at a time on start.
//  - Each 4-bit result is captured and handed downstream on a valid/ready handshake.
//  - Replaces file-driven single-shot stimulus with a reusable on-chip controller in front of the ALU.
// PARAMETERS
//  DEPTH      8   instruction memory depth (power of 2, >=2)
//  AW         3   address width, = log2(DEPTH)
//  SETTLE_CYC 1   cycles alu_inst is held before alu_out is sampled (>=1)
// PORTS
//  clk       in   1      single clock; all state updates on rising edge
//  rst       in   1      asynchronous, active-high reset
//  ld_en     in   1      write ld_data to imem[ld_addr]; honoured only when busy=0
//  ld_addr   in   AW     load address
//  ld_data   in   10     instruction word
//  start     in   1      begin program; sampled only in IDLE
//  prog_len  in   AW+1   number of words to run; values >DEPTH clamp to DEPTH
//  busy      out  1      high in every state except IDLE
//  done      out  1      one-cycle pulse at program end
//  alu_inst  out  10     registered instruction to the ALU
//  alu_out   in   4      ALU result (combinational function of alu_inst)
//  res_valid out  1      result available
//  res_data  out  4      captured result
//  res_idx   out  AW     program index of res_data
//  res_ready in   1      downstream accepts result
//  checksum  out  4      running XOR of accepted results (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; pc=0; state=IDLE; imem contents are NOT reset (they are retained).
//  FSM states: IDLE, ISSUE, SETTLE, HOLD, DONE.
//  - IDLE -> ISSUE: start=1 and prog_len!=0; pc<=0.
//  - IDLE -> DONE:  start=1 and prog_len==0; no result is produced.
//  - ISSUE: alu_inst<=imem[pc]; settle counter<=SETTLE_CYC-1; go to SETTLE.
//  - SETTLE: count down; at 0, res_data<=alu_out, res_idx<=pc, res_valid<=1; go to HOLD.
//  - HOLD: wait for res_valid&res_ready.
//      On the handshake: res_valid<=0.
//      If pc==len-1, go to DONE; otherwise pc<=pc+1 and go to ISSUE.
//  - DONE: done=1 for exactly one cycle; go to IDLE.
//  Timing:
//  - start accepted at edge N -> alu_inst valid after N+1 -> res_valid high after N+1+SETTLE_CYC.
//  - With res_ready held high, one result every SETTLE_CYC+2 cycles.
//  Handshake and data stability:
//  - res_data and res_idx are stable while res_valid=1 and res_ready=0.
//  - alu_inst is held from ISSUE until the next ISSUE; it retains its last value in IDLE.
//  - res_valid is never dropped without a handshake, except by reset.
//  Ignored inputs and simultaneous events:
//  - start while busy is ignored.
//  - ld_en while busy is ignored; imem is write-protected during a run.
//  - ld_en and start in the same IDLE cycle: the write is performed, and the run reads the new word.
//  - Length clamp: len = min(prog_len, DEPTH), latched at start; later changes to prog_len have no effect.
//  - pc never wraps; at most DEPTH issues per run.
//  Reset mid-run: immediate return to IDLE with outputs 0; any pending result is discarded.
// CONFIGURATION
//  Macro ALU_SEQ_CHECKSUM_EN.
//  - Defined: checksum<=0 on an accepted start; checksum<=checksum^res_data on each handshake.
//    The value is final when done pulses.
//  - Undefined: checksum is tied to 4'b0 and no checksum register is built.
// STRUCTURE
//  Shared package alu_seq_pkg:
//  - INST_W=10, RES_W=4.
//  - FSM state encoding: IDLE=0, ISSUE=1, SETTLE=2, HOLD=3, DONE=4, 3 bits.
//  Sub-module alu_seq_imem:
//  - DEPTH x INST_W register array, synchronous write, asynchronous read.
//  - Holds no reset.
// TESTING  (bench ALU model: alu_out = inst[7:4] + inst[3:0], mod 16)
//  1. Load 0x035, 0x011, 0x0FF at addresses 0..2; prog_len=3; start; res_ready=1
//     -> results (idx,data) = (0,8), (1,2), (2,E); done once; checksum=4 if enabled.
//  2. As test 1, but res_ready=0 for 5 cycles at each result
//     -> res_data/res_idx stable throughout; same results in order.
//  3. prog_len=0; start -> done one cycle later; res_valid never asserted; busy high for exactly 1 cycle.
//  4. prog_len=15 with DEPTH=8 -> exactly 8 results, idx 0..7; then done.
//     start and ld_en pulsed during the run -> no effect.
//  5. Assert rst during SETTLE of idx 1 -> all outputs 0 immediately; imem retained.
//     A rerun reproduces test 1.
//  6. SETTLE_CYC=3 -> start at edge N, res_valid at N+4.
//     Inter-result spacing is 5 cycles with res_ready=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared widths and FSM encoding for the ALU instruction sequencer.
package alu_seq_pkg;

  localparam int INST_W = 10;
  localparam int RES_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Result stream from the sequencer to its downstream consumer (valid/ready).
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int AW = 3
) ();

  logic             res_valid;
  logic [RES_W-1:0] res_data;
  logic [AW-1:0]    res_idx;
  logic             res_ready;

  modport master (output res_valid, output res_data, output res_idx, input res_ready);
  modport slave  (input res_valid, input res_data, input res_idx, output res_ready);

endinterface

// File: rtl/alu_seq_imem.sv
// Instruction store: register array with synchronous write and asynchronous read.
module alu_seq_imem
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [DEPTH];

  // NOTE: no reset on the array; the program must survive a reset, and a
  // reset here would also stop the array mapping onto plain storage.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_inst_sequencer.sv
// Issues stored 10-bit instruction words to a combinational ALU and streams the results.
// Optional macro ALU_SEQ_CHECKSUM_EN builds a running XOR of accepted results.
module alu_inst_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [INST_W-1:0] ld_data,
  input  logic              start,
  input  logic [AW:0]       prog_len,
  output logic              busy,
  output logic              done,
  output logic [INST_W-1:0] alu_inst,
  input  logic [RES_W-1:0]  alu_out,
  alu_seq_if.master         res,
  output logic [RES_W-1:0]  checksum
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t            state_q, state_d;
  logic [AW-1:0]     pc_q;
  logic [AW:0]       len_q;
  logic [CW-1:0]     cnt_q;
  logic [INST_W-1:0] alu_inst_q;
  logic              res_valid_q;
  logic [RES_W-1:0]  res_data_q;
  logic [AW-1:0]     res_idx_q;
  logic [INST_W-1:0] imem_rdata;
  logic [AW:0]       len_clamped;
  logic              last;
  logic              handshake;

  alu_seq_imem #(.DEPTH(DEPTH), .AW(AW)) u_imem (
    .clk   (clk),
    .we    (ld_en && (state_q == S_IDLE)),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (pc_q),
    .rdata (imem_rdata)
  );

  assign len_clamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
  assign last        = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
  assign handshake   = (state_q == S_HOLD) && res_valid_q && res.res_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = (prog_len == '0) ? S_DONE : S_ISSUE;
      S_ISSUE:  state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == '0) state_d = S_HOLD;
      S_HOLD:   if (handshake) state_d = last ? S_DONE : S_ISSUE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      alu_inst_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_q  <= '0;
            len_q <= len_clamped;
          end
        end
        S_ISSUE: begin
          alu_inst_q <= imem_rdata;
          cnt_q      <= CW'(SETTLE_CYC - 1);
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            res_data_q  <= alu_out;
            res_idx_q   <= pc_q;
            res_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_HOLD: begin
          if (handshake) begin
            res_valid_q <= 1'b0;
            // pc stops at the last word so it can never wrap past DEPTH issues
            if (!last) pc_q <= pc_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_CHECKSUM_EN
  logic [RES_W-1:0] checksum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              checksum_q <= '0;
    else if ((state_q == S_IDLE) && start) checksum_q <= '0;
    else if (handshake)                   checksum_q <= checksum_q ^ res_data_q;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign alu_inst      = alu_inst_q;
  assign res.res_valid = res_valid_q;
  assign res.res_data  = res_data_q;
  assign res.res_idx   = res_idx_q;

endmodule

// File: tb/tb_alu_inst_sequencer.sv
// Scoreboard bench for alu_inst_sequencer; a second instance runs with SETTLE_CYC=3.
module tb_alu_inst_sequencer;
  import alu_seq_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef ALU_SEQ_CHECKSUM_EN
  localparam logic [3:0] EXP_CK = 4'h4;
`else
  localparam logic [3:0] EXP_CK = 4'h0;
`endif

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [3:0]    data;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic ld_en;
  logic [AW-1:0] ld_addr;
  logic [9:0] ld_data;
  logic start, start3;
  logic [AW:0] prog_len;
  logic busy, done, busy3, done3;
  logic [9:0] alu_inst, alu_inst3;
  logic [3:0] alu_out, alu_out3, checksum, checksum3;

  alu_seq_if #(.AW(AW)) bus  ();
  alu_seq_if #(.AW(AW)) bus3 ();

  always #5 clk = ~clk;

  // Bench ALU: low nibble of inst[7:4] + inst[3:0]
  assign alu_out  = alu_inst[7:4]  + alu_inst[3:0];
  assign alu_out3 = alu_inst3[7:4] + alu_inst3[3:0];

  alu_inst_sequencer #(.DEPTH(DEPTH), .AW(AW), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .prog_len(prog_len), .busy(busy), .done(done),
    .alu_inst(alu_inst), .alu_out(alu_out), .res(bus), .checksum(checksum)
  );

  alu_inst_sequencer #(.DEPTH(DEPTH), .AW(AW), .SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start3), .prog_len(prog_len), .busy(busy3), .done(done3),
    .alu_inst(alu_inst3), .alu_out(alu_out3), .res(bus3), .checksum(checksum3)
  );

  int   checks    = 0;
  int   failures  = 0;
  int   done_cnt  = 0;
  int   cyc       = 0;
  res_t sb_q[$];
  logic [9:0] prog1 [3] = '{10'h035, 10'h011, 10'h0FF};
  logic [9:0] prog8 [DEPTH];

  function automatic logic [3:0] alu_model(input logic [9:0] w);
    return w[7:4] + w[3:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Scoreboard: compare each result at the negedge preceding its handshake
  always @(negedge clk) begin : monitor
    res_t e;
    if (rst === 1'b0 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got idx=%0d data=%h, required no result", bus.res_idx, bus.res_data);
      end else begin
        e = sb_q.pop_front();
        if ({bus.res_idx, bus.res_data} !== e) begin
          failures++;
          $display("FAIL result: got idx=%0d data=%h, required idx=%0d data=%h",
                   bus.res_idx, bus.res_data, e.idx, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [9:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic load_prog1();
    for (int i = 0; i < 3; i++) load_word(AW'(i), prog1[i]);
  endtask

  task automatic push_prog1();
    for (int i = 0; i < 3; i++) sb_q.push_back('{idx: AW'(i), data: alu_model(prog1[i])});
  endtask

  task automatic run(input logic [AW:0] len);
    prog_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: done not seen within %0d cycles, required a done pulse", name, budget);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic check_ck(input string name);
    checks++;
    if (checksum !== EXP_CK) begin
      failures++;
      $display("FAIL %s: got checksum=%h, required %h", name, checksum, EXP_CK);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, alu_inst, bus.res_valid, bus.res_data, bus.res_idx, checksum} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b inst=%h valid=%b data=%h idx=%0d ck=%h, required all 0",
               busy, done, alu_inst, bus.res_valid, bus.res_data, bus.res_idx, checksum);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bus.res_ready = 1'b1;
    load_prog1();
    push_prog1();
    done_cnt = 0;
    run(4'd3);
    wait_done(40, "basic_done");
    check_ck("basic_checksum");
    repeat (3) tick();
    check_int("basic_sb_empty", sb_q.size(), 0);
    check_int("basic_done_cycles", done_cnt, 1);
  endtask

  task automatic test_backpressure();
    bit seen;
    res_t exp;
    bus.res_ready = 1'b0;
    push_prog1();
    done_cnt = 0;
    run(4'd3);
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (bus.res_valid === 1'b1) seen = 1'b1;
      end
      check_int("bp_valid_seen", int'(seen), 1);
      exp = '{idx: AW'(k), data: alu_model(prog1[k])};
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b1 || {bus.res_idx, bus.res_data} !== exp) begin
          failures++;
          $display("FAIL bp_stable: got valid=%b idx=%0d data=%h, required valid=1 idx=%0d data=%h",
                   bus.res_valid, bus.res_idx, bus.res_data, exp.idx, exp.data);
        end
      end
      @(posedge clk); #1;
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
    end
    wait_done(20, "bp_done");
    check_ck("bp_checksum");
    bus.res_ready = 1'b1;
    repeat (2) tick();
    check_int("bp_sb_empty", sb_q.size(), 0);
    check_int("bp_done_cycles", done_cnt, 1);
  endtask

  task automatic test_zero_len();
    int busy_cyc = 0;
    int valid_cyc = 0;
    done_cnt = 0;
    run(4'd0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      failures++;
      $display("FAIL zero_done: got busy=%b done=%b, required busy=1 done=1", busy, done);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
      if (bus.res_valid === 1'b1) valid_cyc++;
    end
    check_int("zero_busy_cycles", busy_cyc, 1);
    check_int("zero_valid_cycles", valid_cyc, 0);
    check_int("zero_done_cycles", done_cnt, 1);
    check_int("zero_checksum", int'(checksum), 0);
    tick();
  endtask

  task automatic test_clamp_and_protect();
    for (int i = 0; i < DEPTH; i++) begin
      prog8[i] = 10'(i * 37 + 5);
      load_word(AW'(i), prog8[i]);
      sb_q.push_back('{idx: AW'(i), data: alu_model(prog8[i])});
    end
    done_cnt = 0;
    run(4'd15);
    repeat (4) tick();
    start = 1'b1; ld_en = 1'b1; ld_addr = '0; ld_data = 10'h3FF; prog_len = 4'd2;
    tick();
    start = 1'b0; ld_en = 1'b0;
    repeat (7) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(60, "clamp_done");
    repeat (4) tick();
    check_int("clamp_sb_empty", sb_q.size(), 0);
    check_int("clamp_done_cycles", done_cnt, 1);
    check_int("clamp_idle_after", int'(busy), 0);
    sb_q.push_back('{idx: '0, data: alu_model(prog8[0])});
    run(4'd1);
    wait_done(20, "protect_done");
    tick();
    check_int("protect_sb_empty", sb_q.size(), 0);
  endtask

  task automatic test_ld_with_start();
    ld_en = 1'b1; ld_addr = '0; ld_data = 10'h077;
    sb_q.push_back('{idx: '0, data: 4'hE});
    run(4'd1);
    ld_en = 1'b0;
    wait_done(20, "ldstart_done");
    tick();
    check_int("ldstart_sb_empty", sb_q.size(), 0);
  endtask

  task automatic test_reset_mid_run();
    bit seen = 1'b0;
    load_prog1();
    push_prog1();
    run(4'd3);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sb_q.size() == 2) seen = 1'b1;
    end
    check_int("midrst_first_result", int'(seen), 1);
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (alu_inst !== prog1[1]) begin
      failures++;
      $display("FAIL midrst_issued: got inst=%h, required %h", alu_inst, prog1[1]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, alu_inst, bus.res_valid, bus.res_data, bus.res_idx, checksum} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got busy=%b done=%b inst=%h valid=%b data=%h idx=%0d ck=%h, required all 0",
               busy, done, alu_inst, bus.res_valid, bus.res_data, bus.res_idx, checksum);
    end
    check_int("midrst_pending", sb_q.size(), 2);
    sb_q.delete();
    tick();
    rst = 1'b0;
    tick();
    push_prog1();
    done_cnt = 0;
    run(4'd3);
    wait_done(40, "rerun_done");
    check_ck("rerun_checksum");
    repeat (3) tick();
    check_int("rerun_sb_empty", sb_q.size(), 0);
    check_int("rerun_done_cycles", done_cnt, 1);
  endtask

  task automatic test_settle3();
    int n;
    int rises = 0;
    int rise_cyc [3];
    logic prev = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus3.res_ready = 1'b1;
    tick();
    prog_len = 4'd3; start3 = 1'b1;
    @(posedge clk); #1;
    n = cyc;
    start3 = 1'b0;
    for (int i = 0; i < 60 && rises < 3; i++) begin
      @(negedge clk);
      if (bus3.res_valid === 1'b1 && prev !== 1'b1) begin
        rise_cyc[rises] = cyc;
        checks++;
        if (bus3.res_data !== alu_model(prog1[rises]) || bus3.res_idx !== AW'(rises)) begin
          failures++;
          $display("FAIL settle3_result: got idx=%0d data=%h, required idx=%0d data=%h",
                   bus3.res_idx, bus3.res_data, rises, alu_model(prog1[rises]));
        end
        rises++;
      end
      prev = bus3.res_valid;
    end
    check_int("settle3_rises", rises, 3);
    if (rises == 3) begin
      check_int("settle3_latency", rise_cyc[0] - n, 4);
      check_int("settle3_spacing1", rise_cyc[1] - rise_cyc[0], 5);
      check_int("settle3_spacing2", rise_cyc[2] - rise_cyc[1], 5);
    end
    repeat (6) tick();
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; start3 = 1'b0; prog_len = '0;
    bus.res_ready = 1'b0; bus3.res_ready = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_clamp_and_protect();
    test_ld_with_start();
    test_reset_mid_run();
    test_settle3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
